// File: rtl/pixel_pos.sv
// Serpentine pixel-position generator: walks a latched frame row by row, going right
// on even rows and left on odd rows, with one downward step at each row end.
module pixel_pos #(
  parameter int X_MAX = 300,
  parameter int Y_MAX = 300,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          update_pos,
  input  logic          new_trans,
  input  logic [XW-1:0] max_x,
  input  logic [YW-1:0] max_y,
  output logic          end_pos,
  output logic [1:0]    next_dir,
  output logic [XW-1:0] curr_x,
  output logic [YW-1:0] curr_y,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] r_mx_m1;
  logic [YW-1:0] r_my_m1;
  logic          r_end_pos;

  logic [XW-1:0] w_mx_m1_in;
  logic [YW-1:0] w_my_m1_in;
  logic          w_one_pixel;
  logic [1:0]    w_dir;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic [XW-1:0] w_last_x;
  logic          w_hit_last;

  // A zero dimension is treated as one, so the stored "size minus one" floors at 0.
  assign w_mx_m1_in  = (max_x == '0) ? '0 : max_x - XW'(1);
  assign w_my_m1_in  = (max_y == '0) ? '0 : max_y - YW'(1);
  assign w_one_pixel = (w_mx_m1_in == '0) && (w_my_m1_in == '0);

  always_comb begin
    w_dir = DIR_RIGHT;
    if (r_state == S_SCAN) begin
      if (!r_y[0] && (r_x < r_mx_m1))
        w_dir = DIR_RIGHT;
      else if (r_y[0] && (r_x != '0))
        w_dir = DIR_LEFT;
      else
        w_dir = DIR_DOWN;
    end
  end

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    case (w_dir)
      DIR_RIGHT: w_nx = r_x + XW'(1);
      DIR_LEFT:  w_nx = r_x - XW'(1);
      default:   w_ny = r_y + YW'(1);
    endcase
  end

  // The final row ends on the right edge if it is even, on the left edge if odd.
  assign w_last_x   = r_my_m1[0] ? '0 : r_mx_m1;
  assign w_hit_last = (w_nx == w_last_x) && (w_ny == r_my_m1);

  // update_pos is a level strobe: every edge it is high during SCAN makes one move;
  // new_trans wins over update_pos in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_mx_m1   <= '0;
      r_my_m1   <= '0;
      r_end_pos <= 1'b0;
    end else if (new_trans) begin
      r_mx_m1   <= w_mx_m1_in;
      r_my_m1   <= w_my_m1_in;
      r_x       <= '0;
      r_y       <= '0;
      r_state   <= w_one_pixel ? S_DONE : S_SCAN;
      r_end_pos <= w_one_pixel;
    end else if ((r_state == S_SCAN) && update_pos) begin
      r_x <= w_nx;
      r_y <= w_ny;
      if (w_hit_last) begin
        r_state   <= S_DONE;
        r_end_pos <= 1'b1;
      end
    end
  end

  assign end_pos   = r_end_pos;
  assign next_dir  = w_dir;
  assign curr_x    = r_x;
  assign curr_y    = r_y;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pixel_pos.sv
// Bench for pixel_pos: directed frame walks plus random traffic, checked against a
// model that derives position from a step index along the serpentine path.
module tb_pixel_pos;

  localparam int XW = 9;
  localparam int YW = 9;
  localparam int W  = XW + YW + 1 + 2;

  logic          clk;
  logic          n_rst;
  logic          update_pos;
  logic          new_trans;
  logic [XW-1:0] max_x;
  logic [YW-1:0] max_y;
  logic          end_pos;
  logic [1:0]    next_dir;
  logic [XW-1:0] curr_x;
  logic [YW-1:0] curr_y;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: frame loaded flag, dims, and index along the path
  bit m_loaded;
  int m_mx;
  int m_my;
  int m_idx;

  logic [W-1:0] exp_q[$];

  pixel_pos #(.X_MAX(300), .Y_MAX(300)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .update_pos (update_pos),
    .new_trans  (new_trans),
    .max_x      (max_x),
    .max_y      (max_y),
    .end_pos    (end_pos),
    .next_dir   (next_dir),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_loaded = 1'b0;
    m_mx = 1;
    m_my = 1;
    m_idx = 0;
  endtask

  task automatic model_apply(input bit upd, input bit nt, input int mx, input int my);
    if (nt) begin
      m_mx = (mx == 0) ? 1 : mx;
      m_my = (my == 0) ? 1 : my;
      m_idx = 0;
      m_loaded = 1'b1;
    end else if (upd && m_loaded && (m_idx < m_mx * m_my - 1)) begin
      m_idx++;
    end
  endtask

  task automatic model_push();
    int ex, ey, r, total;
    logic ee;
    logic [1:0] ed;
    ex = 0; ey = 0; ee = 1'b0; ed = 2'b00;
    if (m_loaded) begin
      total = m_mx * m_my;
      ey = m_idx / m_mx;
      r  = m_idx % m_mx;
      ex = (ey % 2 == 0) ? r : (m_mx - 1 - r);
      ee = (m_idx == total - 1);
      if (!ee) begin
        if ((m_idx + 1) / m_mx != ey) ed = 2'b10;
        else if (ey % 2 == 0)         ed = 2'b00;
        else                          ed = 2'b01;
      end
    end
    exp_q.push_back({XW'(ex), YW'(ey), ee, ed});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag);
    logic [W-1:0] e;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic ee;
    logic [1:0] ed;
    n_tests++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty got 0 entries exp 1", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      {ex, ey, ee, ed} = e;
      n_tests++;
      assert (curr_x === ex) else begin
        n_fail++;
        $error("FAIL %s curr_x got %0d exp %0d", tag, curr_x, ex);
      end
      n_tests++;
      assert (curr_y === ey) else begin
        n_fail++;
        $error("FAIL %s curr_y got %0d exp %0d", tag, curr_y, ey);
      end
      n_tests++;
      assert (end_pos === ee) else begin
        n_fail++;
        $error("FAIL %s end_pos got %0b exp %0b", tag, end_pos, ee);
      end
      n_tests++;
      assert (next_dir === ed) else begin
        n_fail++;
        $error("FAIL %s next_dir got %0b exp %0b", tag, next_dir, ed);
      end
    end
  endtask

  task automatic chk_val(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, take one rising edge, then check at the next negedge.
  task automatic step(input bit upd, input bit nt, input int mx, input int my, input string tag);
    update_pos = upd;
    new_trans  = nt;
    max_x      = XW'(mx);
    max_y      = YW'(my);
    @(posedge clk);
    model_apply(upd, nt, mx, my);
    model_push();
    @(negedge clk);
    check(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_rst = 1'b0;
    update_pos = 1'b0;
    new_trans = 1'b0;
    max_x = '0;
    max_y = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    model_push();
    check("reset");
    n_rst = 1'b1;

    // no frame loaded: pulses must not move anything
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, $urandom_range(1, 20), $urandom_range(1, 20), "idle_pulse");

    // 5x5 walk, pulses spaced 4 cycles
    step(1'b0, 1'b1, 5, 5, "nt_5x5");
    for (int p = 1; p <= 24; p++) begin
      step(1'b1, 1'b0, $urandom_range(0, 30), $urandom_range(0, 30), "walk5");
      if (p == 4)  chk_val("dir_at_4_0", next_dir, 2);
      if (p == 6)  chk_val("dir_at_3_1", next_dir, 1);
      if (p == 9)  chk_val("dir_at_0_1", next_dir, 2);
      if (p == 23) chk_val("end_before_last", end_pos, 0);
      for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 5, 5, "gap5");
    end
    chk_val("end5_x", curr_x, 4);
    chk_val("end5_y", curr_y, 4);
    chk_val("end5_flag", end_pos, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5, 5, "done_hold");

    // 10x10 with update_pos held high for 99 cycles
    step(1'b0, 1'b1, 10, 10, "nt_10x10");
    for (int i = 0; i < 99; i++) step(1'b1, 1'b0, 10, 10, "walk10");
    chk_val("end10_x", curr_x, 0);
    chk_val("end10_y", curr_y, 9);
    chk_val("end10_flag", end_pos, 1);

    // new_trans mid-frame at (2,3) with update_pos high
    step(1'b0, 1'b1, 5, 5, "nt_5x5_b");
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 5, 5, "walk_to_2_3");
    chk_val("mid_x", curr_x, 2);
    chk_val("mid_y", curr_y, 3);
    step(1'b1, 1'b1, 7, 6, "nt_midframe");
    chk_val("mid_home_x", curr_x, 0);
    chk_val("mid_home_end", end_pos, 0);
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0, 3, 3, "walk7x6");
    chk_val("end7x6_x", curr_x, 0);
    chk_val("end7x6_y", curr_y, 5);

    // degenerate dimensions
    step(1'b0, 1'b1, 1, 4, "nt_1x4");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1, 4, "walk1x4");
    chk_val("end1x4_y", curr_y, 3);
    step(1'b0, 1'b1, 3, 1, "nt_3x1");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3, 1, "walk3x1");
    chk_val("end3x1_x", curr_x, 2);
    step(1'b1, 1'b1, 1, 1, "nt_1x1");
    chk_val("end1x1_flag", end_pos, 1);
    step(1'b1, 1'b1, 0, 0, "nt_0x0");
    step(1'b1, 1'b0, 0, 0, "hold_0x0");

    // random traffic with occasional restarts and noisy dimension ports
    for (int f = 0; f < 8; f++) begin
      step(1'b0, 1'b1, $urandom_range(0, 12), $urandom_range(0, 12), "rnd_nt");
      for (int c = 0; c < 200; c++)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
             $urandom_range(0, 12), $urandom_range(0, 12), "rnd");
    end

    // asynchronous reset mid-frame
    step(1'b0, 1'b1, 6, 6, "nt_pre_reset");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6, 6, "pre_reset");
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    model_push();
    check("async_reset");
    @(negedge clk);
    n_rst = 1'b1;
    step(1'b1, 1'b0, 6, 6, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
